// File: rtl/time_counter_if.sv
// time_counter_if: button inputs and display-side outputs of the BCD timekeeping core.
//   btn_mode, btn_inc    raw push buttons (active-high, asynchronous to clk)
//   number0..number5     BCD digits: S ones, S tens, M ones, M tens, H ones, H tens
//   set_mode             00 RUN, 01 SET_HR, 10 SET_MIN
//   sec_tick             one-cycle pulse per prescaler wrap
//   pm                   PM flag (12-hour build only, otherwise 0)
// Modport master is the timekeeping core; slave is the button/display side.
interface time_counter_if;
  logic       btn_mode;
  logic       btn_inc;
  logic [3:0] number0;
  logic [3:0] number1;
  logic [3:0] number2;
  logic [3:0] number3;
  logic [3:0] number4;
  logic [3:0] number5;
  logic [1:0] set_mode;
  logic       sec_tick;
  logic       pm;

  modport master (
    input  btn_mode, btn_inc,
    output number0, number1, number2, number3, number4, number5,
    output set_mode, sec_tick, pm
  );

  modport slave (
    output btn_mode, btn_inc,
    input  number0, number1, number2, number3, number4, number5,
    input  set_mode, sec_tick, pm
  );
endinterface

// File: rtl/time_counter.sv
// time_counter: BCD hours/minutes/seconds core for a six-digit 7-segment clock.
// Divides clk to a 1 Hz tick, counts time in BCD and lets the user set hours and
// minutes with a mode and an increment button (synchronized and debounced here).
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-high reset
//   bus   time_counter_if.master: btn_mode/btn_inc in; number0..5, set_mode,
//         sec_tick, pm out (all outputs registered)
// Parameters: CLK_HZ (prescaler period), DEBOUNCE_CYCLES (stable cycles to accept
// a button level change).
// Build option: define TIME_COUNTER_12H_EN for 12-hour mode (hours 12,01..11 and
// a PM flag); otherwise hours run 00..23 and pm stays 0.
module time_counter #(
  parameter int unsigned CLK_HZ          = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input logic            clk,
  input logic            rst,
  time_counter_if.master bus
);

  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [DW-1:0] DB_MAX    = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    StRun    = 2'b00,
    StSetHr  = 2'b01,
    StSetMin = 2'b10
  } state_e;

  // ---------------------------------------------------------------------------
  // Button path: bit 0 = mode, bit 1 = inc
  // ---------------------------------------------------------------------------
  logic [1:0]    raw;
  logic [1:0]    sync1_q, sync2_q;
  logic [1:0]    deb_q, deb_prev_q;
  logic [1:0]    press_q;
  logic [DW-1:0] db_cnt_q [2];
  logic          mode_evt, inc_evt;

  assign raw = {bus.btn_inc, bus.btn_mode};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      deb_q       <= '0;
      deb_prev_q  <= '0;
      press_q     <= '0;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      // Registered rising edge of the debounced level; releases give nothing.
      press_q    <= deb_q & ~deb_prev_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_MAX) begin
          deb_q[i]    <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Mode wins over a coincident increment.
  assign mode_evt = press_q[0];
  assign inc_evt  = press_q[1] & ~press_q[0];

  // ---------------------------------------------------------------------------
  // Mode FSM
  // ---------------------------------------------------------------------------
  state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (mode_evt) begin
      unique case (state_q)
        StRun:    state_d = StSetHr;
        StSetHr:  state_d = StSetMin;
        default:  state_d = StRun;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Prescaler: runs only in RUN, held at 0 while setting so the first tick after
  // leaving SET_MIN comes a full period later.
  // ---------------------------------------------------------------------------
  logic [PW-1:0] presc_q;
  logic          sec_tick_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q    <= '0;
      sec_tick_q <= 1'b0;
    end else begin
      sec_tick_q <= (state_q == StRun) && (presc_q == PRESC_MAX);
      if ((state_q != StRun) || (presc_q == PRESC_MAX)) begin
        presc_q <= '0;
      end else begin
        presc_q <= presc_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Time digits
  // ---------------------------------------------------------------------------
  logic [3:0] h1_q, h0_q, m1_q, m0_q, s1_q, s0_q;
  logic [3:0] h1_d, h0_d, m1_d, m0_d, s1_d, s0_d;
  logic [3:0] h1_inc, h0_inc, m1_inc, m0_inc;
  logic       pm_q, pm_d, pm_flip;

  // Incremented hour/minute values, shared by the RUN cascade and the set modes.
  always_comb begin
    m0_inc  = (m0_q == 4'd9) ? 4'd0 : m0_q + 4'd1;
    m1_inc  = (m0_q == 4'd9) ? ((m1_q == 4'd5) ? 4'd0 : m1_q + 4'd1) : m1_q;
    pm_flip = 1'b0;
`ifdef TIME_COUNTER_12H_EN
    if (h1_q == 4'd1 && h0_q == 4'd2) begin
      h1_inc = 4'd0;
      h0_inc = 4'd1;
    end else if (h1_q == 4'd1 && h0_q == 4'd1) begin
      h1_inc  = 4'd1;
      h0_inc  = 4'd2;
      pm_flip = 1'b1;
    end else if (h0_q == 4'd9) begin
      h1_inc = 4'd1;
      h0_inc = 4'd0;
    end else begin
      h1_inc = h1_q;
      h0_inc = h0_q + 4'd1;
    end
`else
    if (h1_q == 4'd2 && h0_q == 4'd3) begin
      h1_inc = 4'd0;
      h0_inc = 4'd0;
    end else if (h0_q == 4'd9) begin
      h1_inc = h1_q + 4'd1;
      h0_inc = 4'd0;
    end else begin
      h1_inc = h1_q;
      h0_inc = h0_q + 4'd1;
    end
`endif
  end

  always_comb begin
    h1_d = h1_q;
    h0_d = h0_q;
    m1_d = m1_q;
    m0_d = m0_q;
    s1_d = s1_q;
    s0_d = s0_q;
    pm_d = pm_q;
    unique case (state_q)
      StRun: begin
        // Whole cascade resolves in one cycle so no intermediate digits appear.
        if (sec_tick_q) begin
          if (s0_q == 4'd9) begin
            s0_d = 4'd0;
            if (s1_q == 4'd5) begin
              s1_d = 4'd0;
              m1_d = m1_inc;
              m0_d = m0_inc;
              if (m1_q == 4'd5 && m0_q == 4'd9) begin
                h1_d = h1_inc;
                h0_d = h0_inc;
                pm_d = pm_q ^ pm_flip;
              end
            end else begin
              s1_d = s1_q + 4'd1;
            end
          end else begin
            s0_d = s0_q + 4'd1;
          end
        end
      end
      StSetHr: begin
        if (inc_evt) begin
          h1_d = h1_inc;
          h0_d = h0_inc;
          pm_d = pm_q ^ pm_flip;
        end
      end
      StSetMin: begin
        if (inc_evt) begin
          m1_d = m1_inc;
          m0_d = m0_inc;
        end
        if (mode_evt) begin
          s1_d = 4'd0;
          s0_d = 4'd0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
`ifdef TIME_COUNTER_12H_EN
      h1_q    <= 4'd1;
      h0_q    <= 4'd2;
`else
      h1_q    <= 4'd0;
      h0_q    <= 4'd0;
`endif
      m1_q    <= 4'd0;
      m0_q    <= 4'd0;
      s1_q    <= 4'd0;
      s0_q    <= 4'd0;
      pm_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      h1_q    <= h1_d;
      h0_q    <= h0_d;
      m1_q    <= m1_d;
      m0_q    <= m0_d;
      s1_q    <= s1_d;
      s0_q    <= s0_d;
      // pm_flip is constant 0 in the 24-hour build, so this flop stays at 0.
      pm_q    <= pm_d;
    end
  end

  assign bus.number0  = s0_q;
  assign bus.number1  = s1_q;
  assign bus.number2  = m0_q;
  assign bus.number3  = m1_q;
  assign bus.number4  = h0_q;
  assign bus.number5  = h1_q;
  assign bus.set_mode = state_q;
  assign bus.sec_tick = sec_tick_q;
  assign bus.pm       = pm_q;

endmodule

// File: tb/tb_time_counter.sv
// Self-checking bench for time_counter (CLK_HZ=10, DEBOUNCE_CYCLES=4).
// Stimulus pushes the expected output tuple and the cycle it must appear on; the
// monitor pops one entry every time the observed tuple changes.
// Tuple = {H tens, H ones, M tens, M ones, S tens, S ones, set_mode, sec_tick, pm}.
// Compile with TIME_COUNTER_12H_EN defined to exercise the 12-hour build.
module tb_time_counter;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  time_counter_if bus ();

  time_counter #(
    .CLK_HZ         (10),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard
  logic [27:0] q_val [$];
  int          q_cyc [$];
  string       q_tag [$];
  int          n_checks = 0;
  int          n_pass   = 0;
  bit          first    = 1'b1;
  logic [27:0] prev;

  // Reference time model
  int         th, tm, ts;
  logic       pmx = 1'b0;
  logic [1:0] mx  = 2'b00;
  int         base, ticks, last_press;

`ifdef TIME_COUNTER_12H_EN
  localparam int HrTarget = 11;
`else
  localparam int HrTarget = 23;
`endif

  function automatic logic [27:0] cur_exp(input logic tick);
    return {4'(th / 10), 4'(th % 10), 4'(tm / 10), 4'(tm % 10), 4'(ts / 10), 4'(ts % 10),
            mx, tick, pmx};
  endfunction

  task automatic push(input int c, input logic [27:0] v, input string tag);
    q_cyc.push_back(c);
    q_val.push_back(v);
    q_tag.push_back(tag);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic adv_hour();
`ifdef TIME_COUNTER_12H_EN
    if (th == 11) begin
      th  = 12;
      pmx = ~pmx;
    end else if (th == 12) begin
      th = 1;
    end else begin
      th = th + 1;
    end
`else
    th = (th + 1) % 24;
`endif
  endtask

  // Queue the tick pulse and the following digit change for ticks up to k,
  // counted from base (the edge where the prescaler last sat at 0), then wait.
  task automatic tick_to(input int k);
    while (ticks < k) begin
      ticks = ticks + 1;
      push(base + 10 * ticks, cur_exp(1'b1), "tick_pulse");
      ts = ts + 1;
      if (ts == 60) begin
        ts = 0;
        tm = tm + 1;
        if (tm == 60) begin
          tm = 0;
          adv_hour();
        end
      end
      push(base + 10 * ticks + 1, cur_exp(1'b0), "tick_digits");
    end
    while (cyc < base + 10 * k + 1) step();
  endtask

  // Held press: raw edge at N, result expected at N+8; model already updated.
  task automatic press(input logic m, input logic i, input string tag);
    int n;
    n = cyc;
    last_press = n;
    push(n + 8, cur_exp(1'b0), tag);
    bus.btn_mode = m;
    bus.btn_inc  = i;
    repeat (10) step();
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    repeat (7) step();
  endtask

  always @(negedge clk) begin : mon
    logic [27:0] cur;
    logic [27:0] ev;
    int          ec;
    string       et;
    cur = {bus.number5, bus.number4, bus.number3, bus.number2, bus.number1, bus.number0,
           bus.set_mode, bus.sec_tick, bus.pm};
    if (first || cur != prev) begin
      first = 1'b0;
      n_checks = n_checks + 1;
      if (q_val.size() == 0) begin
        $display("FAIL unexpected_change: got %h at cycle %0d, want no change", cur, cyc);
      end else begin
        ev = q_val.pop_front();
        ec = q_cyc.pop_front();
        et = q_tag.pop_front();
        if (cur == ev && (ec < 0 || ec == cyc)) n_pass = n_pass + 1;
        else $display("FAIL %s: got %h at cycle %0d, want %h at cycle %0d", et, cur, cyc, ev, ec);
      end
    end
    prev = cur;
  end

  initial begin
    rst          = 1'b0;
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
`ifdef TIME_COUNTER_12H_EN
    th = 12;
`else
    th = 0;
`endif
    tm = 0;
    ts = 0;
    #2 rst = 1'b1;
    push(-1, cur_exp(1'b0), "reset_state");
    repeat (3) step();
    rst   = 1'b0;
    base  = cyc;
    ticks = 0;
    tick_to(2);

    // Reset mid-count with a debounce in progress: nothing survives it.
    step();
    bus.btn_mode = 1'b1;
    repeat (3) step();
    rst = 1'b1;
    ts  = 0;
    push(cyc, cur_exp(1'b0), "reset_midcount");
    step();
    bus.btn_mode = 1'b0;
    repeat (2) step();
    rst   = 1'b0;
    base  = cyc;
    ticks = 0;
    tick_to(1);

    // 3-cycle glitch: no mode change.
    bus.btn_mode = 1'b1;
    repeat (3) step();
    bus.btn_mode = 1'b0;
    tick_to(2);

    // Held press into SET_HR, then 25 hour increments.
    mx = 2'b01;
    press(1'b1, 1'b0, "mode_to_sethr");
    for (int k = 0; k < 25; k++) begin
      adv_hour();
      press(1'b0, 1'b1, "hr_inc");
    end

    // Simultaneous mode+inc: mode wins, hours unchanged.
    mx = 2'b10;
    press(1'b1, 1'b1, "simul_mode_inc");
    for (int k = 0; k < 61; k++) begin
      tm = (tm + 1) % 60;
      press(1'b0, 1'b1, "min_inc");
    end

    // Back to RUN: seconds cleared, first tick a full period later.
    mx = 2'b00;
    ts = 0;
    press(1'b1, 1'b0, "exit_setmin");
    base  = last_press + 8;
    ticks = 0;
    tick_to(2);

    // Preload HrTarget:59 and run up to :58.
    mx = 2'b01;
    press(1'b1, 1'b0, "mode_to_sethr2");
    while (th != HrTarget) begin
      adv_hour();
      press(1'b0, 1'b1, "hr_preload");
    end
    mx = 2'b10;
    press(1'b1, 1'b0, "mode_to_setmin2");
    while (tm != 59) begin
      tm = tm + 1;
      press(1'b0, 1'b1, "min_preload");
    end
    mx = 2'b00;
    ts = 0;
    press(1'b1, 1'b0, "exit_setmin2");
    base  = last_press + 8;
    ticks = 0;
    tick_to(58);

`ifdef TIME_COUNTER_12H_EN
    push(base + 590, {24'h115958, 2'b00, 1'b1, 1'b0}, "pre_noon_tick");
    push(base + 591, {24'h115959, 2'b00, 1'b0, 1'b0}, "pre_noon_digits");
    push(base + 600, {24'h115959, 2'b00, 1'b1, 1'b0}, "noon_tick");
    push(base + 601, {24'h120000, 2'b00, 1'b0, 1'b1}, "noon_pm_set");
    while (cyc < base + 601) step();
    th    = 12;
    tm    = 0;
    ts    = 0;
    pmx   = 1'b1;
    ticks = 60;
    mx    = 2'b01;
    press(1'b1, 1'b0, "mode_to_sethr3");
    mx = 2'b10;
    press(1'b1, 1'b0, "mode_to_setmin3");
    while (tm != 59) begin
      tm = tm + 1;
      press(1'b0, 1'b1, "min_preload3");
    end
    mx = 2'b00;
    ts = 0;
    press(1'b1, 1'b0, "exit_setmin3");
    base  = last_press + 8;
    ticks = 0;
    tick_to(59);
    push(base + 600, {24'h125959, 2'b00, 1'b1, 1'b1}, "one_oclock_tick");
    push(base + 601, {24'h010000, 2'b00, 1'b0, 1'b1}, "one_oclock_digits");
    while (cyc < base + 601) step();
`else
    push(base + 590, {24'h235958, 2'b00, 1'b1, 1'b0}, "pre_midnight_tick");
    push(base + 591, {24'h235959, 2'b00, 1'b0, 1'b0}, "pre_midnight_digits");
    push(base + 600, {24'h235959, 2'b00, 1'b1, 1'b0}, "midnight_tick");
    push(base + 601, {24'h000000, 2'b00, 1'b0, 1'b0}, "midnight_rollover");
    while (cyc < base + 601) step();
`endif

    repeat (5) step();
    n_checks = n_checks + 1;
    if (q_val.size() == 0) n_pass = n_pass + 1;
    else $display("FAIL missing_events: got %0d pending, want 0", q_val.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
